// File: rtl/rr_tdm_demux_if.sv
// Bundle of TDM input words and de-interleaved frame output.
// slave = demux side, master = upstream source / downstream sink.
`timescale 1ns/1ps
interface rr_tdm_demux_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2
);
  localparam int SW = $clog2(NUM_LANES);

  logic [DATA_WIDTH-1:0]           din;
  logic                            din_valid;
  logic                            din_sof;
  logic [NUM_LANES*DATA_WIDTH-1:0] dout;
  logic                            dout_valid;
  logic                            dout_ready;
  logic [SW-1:0]                   slot;
  logic                            sync_err;
  logic                            overrun;

  modport slave (
    input  din, din_valid, din_sof, dout_ready,
    output dout, dout_valid, slot, sync_err, overrun
  );

  modport master (
    output din, din_valid, din_sof, dout_ready,
    input  dout, dout_valid, slot, sync_err, overrun
  );
endinterface

// File: rtl/rr_tdm_demux.sv
// Round-robin TDM receive: de-interleaves one word stream into
// NUM_LANES parallel lanes, presented per frame via valid/ready.
`timescale 1ns/1ps
module rr_tdm_demux #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 2,
  parameter bit USE_SOF    = 1'b1
) (
  input logic           clk,
  input logic           rst,
  rr_tdm_demux_if.slave bus
);
  localparam int SW = $clog2(NUM_LANES);
  localparam int FW = NUM_LANES * DATA_WIDTH;
  localparam logic [SW-1:0] LAST = SW'(NUM_LANES - 1);

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    COLLECT   = 1'b1
  } state_t;

  localparam state_t RST_STATE = USE_SOF ? SYNC_WAIT : COLLECT;

  state_t                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_LANES];
  logic [FW-1:0]         dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic                  overrun_q, overrun_d;
  logic                  commit;

  // Next state: slot capture, SOF resync, frame commit and handshake.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q & ~bus.dout_ready;
    sync_err_d   = 1'b0;
    overrun_d    = 1'b0;
    commit       = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        SYNC_WAIT: begin
          if (bus.din_sof) begin
            shadow_d[0] = bus.din;
            slot_d      = SW'(1);
            state_d     = COLLECT;
          end
        end
        COLLECT: begin
          if (USE_SOF && bus.din_sof && (slot_q != '0)) begin
            // Misaligned SOF: drop partial frame, restart at lane 1.
            sync_err_d  = 1'b1;
            shadow_d[0] = bus.din;
            slot_d      = SW'(1);
          end else begin
            shadow_d[slot_q] = bus.din;
            if (slot_q == LAST) begin
              slot_d = '0;
              commit = 1'b1;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end
        default: state_d = RST_STATE;
      endcase
    end

    if (commit) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = shadow_d[k];
      end
      overrun_d    = dout_valid_q & ~bus.dout_ready;
      dout_valid_d = 1'b1;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_STATE;
      slot_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      overrun_q    <= overrun_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slot       = slot_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_rr_tdm_demux.sv
// Self-checking bench for rr_tdm_demux: a 2-lane SOF-aligned
// instance and a 4-lane count-only instance.
`timescale 1ns/1ps
module tb_rr_tdm_demux;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_tdm_demux_if #(.DATA_WIDTH(16), .NUM_LANES(2)) ifa ();
  rr_tdm_demux_if #(.DATA_WIDTH(16), .NUM_LANES(4)) ifb ();

  rr_tdm_demux #(
    .DATA_WIDTH(16), .NUM_LANES(2), .USE_SOF(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  rr_tdm_demux #(
    .DATA_WIDTH(16), .NUM_LANES(4), .USE_SOF(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  int errs = 0;
  int checks = 0;
  logic [31:0] exp_a [$];
  logic [63:0] exp_b [$];
  logic [31:0] ea;
  logic [63:0] eb;

  // One clock on instance A; outputs sampled 1ns after the edge.
  task automatic cyc_a(input logic v, input logic s,
                       input logic [15:0] d, input logic r);
    @(negedge clk);
    ifa.din_valid  = v;
    ifa.din_sof    = s;
    ifa.din        = d;
    ifa.dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic v, input logic s,
                       input logic [15:0] d, input logic r);
    @(negedge clk);
    ifb.din_valid  = v;
    ifb.din_sof    = s;
    ifb.din        = d;
    ifb.dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifa.din_valid = 1'b0;
    ifb.din_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ifa.dout !== 32'h0) begin
      errs++; $display("FAIL rst_dout: got %h want 0", ifa.dout);
    end
    checks++;
    if (ifa.dout_valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid: got %b want 0", ifa.dout_valid);
    end
    checks++;
    if (ifa.slot !== 1'b0) begin
      errs++; $display("FAIL rst_slot: got %0d want 0", ifa.slot);
    end
    checks++;
    if ({ifa.sync_err, ifa.overrun} !== 2'b00) begin
      errs++;
      $display("FAIL rst_flags: got %b want 00",
               {ifa.sync_err, ifa.overrun});
    end
  endtask

  task automatic test_basic();
    cyc_a(1, 1, 16'h1111, 1);
    checks++;
    if (ifa.dout_valid !== 1'b0 || ifa.slot !== 1'b1) begin
      errs++;
      $display("FAIL basic_mid: got valid=%b slot=%0d want valid=0 slot=1",
               ifa.dout_valid, ifa.slot);
    end
    cyc_a(1, 0, 16'h2222, 1);
    exp_a.push_back(32'h2222_1111);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.dout_valid !== 1'b1 || ifa.dout !== ea) begin
      errs++;
      $display("FAIL basic_frame: got valid=%b dout=%h want valid=1 dout=%h",
               ifa.dout_valid, ifa.dout, ea);
    end
    checks++;
    if ({ifa.sync_err, ifa.overrun} !== 2'b00) begin
      errs++;
      $display("FAIL basic_flags: got %b want 00",
               {ifa.sync_err, ifa.overrun});
    end
    cyc_a(0, 0, 16'h0, 1);
    checks++;
    if (ifa.dout_valid !== 1'b0) begin
      errs++; $display("FAIL basic_consume: got %b want 0", ifa.dout_valid);
    end
  endtask

  task automatic test_sync_wait();
    logic se_seen;
    do_reset();
    se_seen = 1'b0;
    cyc_a(1, 0, 16'hAAAA, 1);
    se_seen |= ifa.sync_err;
    checks++;
    if (ifa.slot !== 1'b0) begin
      errs++; $display("FAIL sw_drop_slot: got %0d want 0", ifa.slot);
    end
    cyc_a(1, 1, 16'hBBBB, 1);
    se_seen |= ifa.sync_err;
    cyc_a(1, 0, 16'hCCCC, 1);
    se_seen |= ifa.sync_err;
    exp_a.push_back(32'hCCCC_BBBB);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.dout_valid !== 1'b1 || ifa.dout !== ea) begin
      errs++;
      $display("FAIL sw_frame: got valid=%b dout=%h want valid=1 dout=%h",
               ifa.dout_valid, ifa.dout, ea);
    end
    checks++;
    if (se_seen !== 1'b0) begin
      errs++; $display("FAIL sw_sync_err: got %b want 0", se_seen);
    end
  endtask

  task automatic test_resync();
    cyc_a(0, 0, 16'h0, 1);
    cyc_a(1, 1, 16'h0101, 1);
    cyc_a(1, 1, 16'h0202, 1);
    checks++;
    if (ifa.sync_err !== 1'b1 || ifa.dout_valid !== 1'b0) begin
      errs++;
      $display("FAIL rs_pulse: got sync_err=%b valid=%b want 1 0",
               ifa.sync_err, ifa.dout_valid);
    end
    cyc_a(1, 0, 16'h0303, 1);
    exp_a.push_back(32'h0303_0202);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.sync_err !== 1'b0) begin
      errs++; $display("FAIL rs_one_cycle: got %b want 0", ifa.sync_err);
    end
    checks++;
    if (ifa.dout_valid !== 1'b1 || ifa.dout !== ea) begin
      errs++;
      $display("FAIL rs_frame: got valid=%b dout=%h want valid=1 dout=%h",
               ifa.dout_valid, ifa.dout, ea);
    end
  endtask

  task automatic test_overrun();
    cyc_a(0, 0, 16'h0, 1);
    cyc_a(1, 1, 16'h1234, 0);
    cyc_a(1, 0, 16'h5678, 0);
    exp_a.push_back(32'h5678_1234);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.dout !== ea || ifa.overrun !== 1'b0) begin
      errs++;
      $display("FAIL ov_f1: got dout=%h ovr=%b want dout=%h ovr=0",
               ifa.dout, ifa.overrun, ea);
    end
    cyc_a(1, 1, 16'h9ABC, 0);
    checks++;
    if (ifa.dout !== ea || ifa.dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL ov_hold: got dout=%h valid=%b want dout=%h valid=1",
               ifa.dout, ifa.dout_valid, ea);
    end
    cyc_a(1, 0, 16'hDEF0, 0);
    exp_a.push_back(32'hDEF0_9ABC);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.overrun !== 1'b1 || ifa.dout !== ea || ifa.dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL ov_f2: got ovr=%b dout=%h valid=%b want 1 %h 1",
               ifa.overrun, ifa.dout, ifa.dout_valid, ea);
    end
    cyc_a(0, 0, 16'h0, 0);
    checks++;
    if (ifa.overrun !== 1'b0 || ifa.dout_valid !== 1'b1) begin
      errs++;
      $display("FAIL ov_after: got ovr=%b valid=%b want 0 1",
               ifa.overrun, ifa.dout_valid);
    end
    cyc_a(0, 0, 16'h0, 1);
    checks++;
    if (ifa.dout_valid !== 1'b0 || ifa.dout !== ea) begin
      errs++;
      $display("FAIL ov_drain: got valid=%b dout=%h want 0 %h",
               ifa.dout_valid, ifa.dout, ea);
    end
  endtask

  task automatic test_back_to_back();
    cyc_a(1, 1, 16'h4444, 0);
    cyc_a(1, 0, 16'h5555, 0);
    exp_a.push_back(32'h5555_4444);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.dout_valid !== 1'b1 || ifa.dout !== ea) begin
      errs++;
      $display("FAIL b2b_f1: got valid=%b dout=%h want 1 %h",
               ifa.dout_valid, ifa.dout, ea);
    end
    cyc_a(1, 1, 16'h6666, 0);
    cyc_a(1, 0, 16'h7777, 1);
    exp_a.push_back(32'h7777_6666);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.dout_valid !== 1'b1 || ifa.dout !== ea || ifa.overrun !== 1'b0) begin
      errs++;
      $display("FAIL b2b_f2: got valid=%b dout=%h ovr=%b want 1 %h 0",
               ifa.dout_valid, ifa.dout, ifa.overrun, ea);
    end
  endtask

  task automatic test_gaps_reset();
    cyc_a(1, 1, 16'h0A0A, 1);
    cyc_a(0, 1, 16'hFFFF, 1);
    cyc_a(0, 0, 16'hEEEE, 1);
    checks++;
    if (ifa.slot !== 1'b1 || ifa.dout_valid !== 1'b0) begin
      errs++;
      $display("FAIL gap_hold: got slot=%0d valid=%b want 1 0",
               ifa.slot, ifa.dout_valid);
    end
    cyc_a(1, 0, 16'h0B0B, 1);
    exp_a.push_back(32'h0B0B_0A0A);
    ea = exp_a.pop_front();
    checks++;
    if (ifa.dout_valid !== 1'b1 || ifa.dout !== ea) begin
      errs++;
      $display("FAIL gap_frame: got valid=%b dout=%h want 1 %h",
               ifa.dout_valid, ifa.dout, ea);
    end
    cyc_a(1, 1, 16'h1357, 1);
    do_reset();
    checks++;
    if (ifa.dout !== 32'h0 || ifa.dout_valid !== 1'b0 || ifa.slot !== 1'b0) begin
      errs++;
      $display("FAIL midrst: got dout=%h valid=%b slot=%0d want 0 0 0",
               ifa.dout, ifa.dout_valid, ifa.slot);
    end
    cyc_a(1, 0, 16'h2468, 1);
    checks++;
    if (ifa.slot !== 1'b0) begin
      errs++; $display("FAIL midrst_needsof: got %0d want 0", ifa.slot);
    end
    cyc_a(0, 0, 16'h0, 1);
  endtask

  task automatic test_count_mode();
    logic [15:0] w;
    logic [63:0] fr;
    logic se_seen;
    do_reset();
    se_seen = 1'b0;
    fr = '0;
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      fr[(i % 4)*16 +: 16] = w;
      cyc_b(1, 1, w, 1);
      se_seen |= ifb.sync_err;
      checks++;
      if (ifb.slot !== 2'((i + 1) % 4)) begin
        errs++;
        $display("FAIL cnt_slot%0d: got %0d want %0d",
                 i, ifb.slot, (i + 1) % 4);
      end
      if ((i % 4) == 3) begin
        exp_b.push_back(fr);
        eb = exp_b.pop_front();
        checks++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== eb) begin
          errs++;
          $display("FAIL cnt_frame%0d: got valid=%b dout=%h want 1 %h",
                   i / 4, ifb.dout_valid, ifb.dout, eb);
        end
      end
    end
    checks++;
    if (se_seen !== 1'b0) begin
      errs++; $display("FAIL cnt_sync_err: got %b want 0", se_seen);
    end
    cyc_b(0, 0, 16'h0, 1);
  endtask

  initial begin
    ifa.din = '0; ifa.din_valid = 0; ifa.din_sof = 0; ifa.dout_ready = 1;
    ifb.din = '0; ifb.din_valid = 0; ifb.din_sof = 0; ifb.dout_ready = 1;
    test_reset();
    test_basic();
    test_sync_wait();
    test_resync();
    test_overrun();
    test_back_to_back();
    test_gaps_reset();
    test_count_mode();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
